// File: rtl/seq_detect_param_if.sv
// Purpose : bundles the serial data, control and result signals of seq_detect_param.
// Latency : none; wiring only.
// Backpressure: none; en qualifies each data bit, nothing can stall the source.
//
// Port summary (all signals are in the clk domain of the attached detector):
//   en, x       : bit-valid strobe and serial data bit
//   ovl         : 1 = overlapping detection, 0 = non-overlapping
//   load,pat_in : capture a new pattern (first-received bit is the MSB)
//   clr_cnt     : synchronous clear of the match counter
//   y, y_q      : Mealy match flag and its registered copy
//   match_cnt   : saturating count of matches
interface seq_detect_param_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
);
    logic             en;
    logic             x;
    logic             ovl;
    logic             load;
    logic [PAT_W-1:0] pat_in;
    logic             clr_cnt;
    logic             y;
    logic             y_q;
    logic [CNT_W-1:0] match_cnt;

    // Stimulus side: drives data/control, observes results.
    modport master (
        output en, x, ovl, load, pat_in, clr_cnt,
        input  y, y_q, match_cnt
    );

    // Detector side.
    modport slave (
        input  en, x, ovl, load, pat_in, clr_cnt,
        output y, y_q, match_cnt
    );
endinterface

// File: rtl/seq_detect_param.sv
// Purpose : programmable serial pattern detector with overlap control and a
//           saturating match counter.
// Latency : y is combinational on the current x (0 cycles); y_q one cycle later.
// Backpressure: none; a bit is consumed on every cycle where en is high.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset
//   bus  - seq_detect_param_if.slave (en, x, ovl, load, pat_in, clr_cnt,
//          y, y_q, match_cnt)
module seq_detect_param #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] DEF_PAT = 4'b1011,
    parameter int               CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    seq_detect_param_if.slave bus
);

    // fill counts 0..PAT_W-1; keep at least one bit for PAT_W == 2.
    localparam int             FW       = (PAT_W > 2) ? $clog2(PAT_W) : 1;
    localparam logic [FW-1:0]  FILL_MAX = FW'(PAT_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [PAT_W-1:0] pat;
    logic [PAT_W-2:0] hist;      // newest received bit in the LSB
    logic [FW-1:0]    fill;      // number of valid bits held in hist
    logic [CNT_W-1:0] cnt;
    logic             y_q_r;

    logic [PAT_W-1:0] window;
    logic             match;
    logic [PAT_W-2:0] hist_nxt;
    logic [FW-1:0]    fill_nxt;
    logic [CNT_W-1:0] cnt_nxt;

    // The candidate window is the stored history with the current bit appended,
    // so a match is reported in the same cycle the last pattern bit arrives.
    assign window = {hist, bus.x};

    // rst gating keeps y low throughout reset even while inputs are active.
    assign match = rst & bus.en & ~bus.load & (fill == FILL_MAX) & (window == pat);

    always_comb begin
        hist_nxt = hist;
        fill_nxt = fill;
        cnt_nxt  = cnt;

        if (bus.load) begin
            // A new pattern invalidates whatever history was collected.
            hist_nxt = '0;
            fill_nxt = '0;
        end else if (bus.en) begin
            if (match && !bus.ovl) begin
                // Non-overlapping: the matched bits cannot be reused.
                hist_nxt = '0;
                fill_nxt = '0;
            end else begin
                // Shifting the window keeps the newest PAT_W-1 bits; on an
                // overlapping match fill is already at its ceiling and stays there.
                hist_nxt = window[PAT_W-2:0];
                if (fill != FILL_MAX) begin
                    fill_nxt = fill + FW'(1);
                end
            end
        end

        // Clear takes priority over a coincident match.
        if (bus.clr_cnt) begin
            cnt_nxt = '0;
        end else if (match && (cnt != CNT_MAX)) begin
            cnt_nxt = cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat   <= DEF_PAT;
            hist  <= '0;
            fill  <= '0;
            cnt   <= '0;
            y_q_r <= 1'b0;
        end else begin
            if (bus.load) begin
                pat <= bus.pat_in;
            end
            hist  <= hist_nxt;
            fill  <= fill_nxt;
            cnt   <= cnt_nxt;
            y_q_r <= match;
        end
    end

    assign bus.y         = match;
    assign bus.y_q       = y_q_r;
    assign bus.match_cnt = cnt;

endmodule

// File: tb/tb_seq_detect_param.sv
module tb_seq_detect_param;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    seq_detect_param_if #(.PAT_W(4), .CNT_W(8)) a ();
    seq_detect_param_if #(.PAT_W(2), .CNT_W(2)) b ();

    seq_detect_param #(.PAT_W(4), .DEF_PAT(4'b1011), .CNT_W(8)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (a.slave)
    );

    seq_detect_param #(.PAT_W(2), .DEF_PAT(2'b11), .CNT_W(2)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        a.en = 1'b0; a.x = 1'b0; a.ovl = 1'b1; a.load = 1'b0; a.pat_in = '0; a.clr_cnt = 1'b0;
        b.en = 1'b0; b.x = 1'b0; b.ovl = 1'b1; b.load = 1'b0; b.pat_in = '0; b.clr_cnt = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        #2 rst = 1'b1;
    endtask

    // Drive one bit on instance a, sample y before the edge and y_q after it.
    task automatic step_a(input logic e, input logic xv, output logic ys, output logic yqs);
        @(negedge clk);
        a.en = e;
        a.x  = xv;
        #1 ys = a.y;
        @(posedge clk);
        #1 yqs = a.y_q;
    endtask

    task automatic step_b(input logic e, input logic xv, output logic ys, output logic yqs);
        @(negedge clk);
        b.en = e;
        b.x  = xv;
        #1 ys = b.y;
        @(posedge clk);
        #1 yqs = b.y_q;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        #1 rst = 1'b0;
        a.en = 1'b1;
        a.x  = 1'b1;
        #3;
        n_tests++;
        if (a.y !== 1'b0) begin n_fail++; $display("FAIL reset_y: got %b expected 0", a.y); end
        n_tests++;
        if (a.y_q !== 1'b0) begin n_fail++; $display("FAIL reset_yq: got %b expected 0", a.y_q); end
        n_tests++;
        if (a.match_cnt !== 8'd0 || b.match_cnt !== 2'd0) begin
            n_fail++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", a.match_cnt, b.match_cnt);
        end
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
    endtask

    task automatic test_overlap();
        logic [6:0] s, gy, gq;
        logic ys, yqs;
        do_reset();
        a.ovl = 1'b1;
        s = 7'b1011011;
        for (int i = 0; i < 7; i++) begin
            step_a(1'b1, s[6-i], ys, yqs);
            gy[6-i] = ys;
            gq[6-i] = yqs;
        end
        n_tests++;
        if (gy !== 7'b0001001) begin n_fail++; $display("FAIL overlap_y: got %b expected 0001001", gy); end
        n_tests++;
        if (gq !== 7'b0001001) begin n_fail++; $display("FAIL overlap_yq: got %b expected 0001001", gq); end
        n_tests++;
        if (a.match_cnt !== 8'd2) begin n_fail++; $display("FAIL overlap_cnt: got %0d expected 2", a.match_cnt); end
    endtask

    task automatic test_nonoverlap();
        logic [6:0] s, gy;
        logic ys, yqs;
        do_reset();
        a.ovl = 1'b0;
        s = 7'b1011011;
        for (int i = 0; i < 7; i++) begin
            step_a(1'b1, s[6-i], ys, yqs);
            gy[6-i] = ys;
        end
        n_tests++;
        if (gy !== 7'b0001000) begin n_fail++; $display("FAIL nonoverlap_y: got %b expected 0001000", gy); end
        n_tests++;
        if (a.match_cnt !== 8'd1) begin n_fail++; $display("FAIL nonoverlap_cnt: got %0d expected 1", a.match_cnt); end
    endtask

    task automatic test_enable();
        logic [6:0] s, e, gy;
        logic ys, yqs;
        do_reset();
        a.ovl = 1'b1;
        s = 7'b1010111;
        e = 7'b1100011;
        for (int i = 0; i < 7; i++) begin
            step_a(e[6-i], s[6-i], ys, yqs);
            gy[6-i] = ys;
        end
        n_tests++;
        if (gy !== 7'b0000001) begin n_fail++; $display("FAIL enable_y: got %b expected 0000001", gy); end
        n_tests++;
        if (a.match_cnt !== 8'd1) begin n_fail++; $display("FAIL enable_cnt: got %0d expected 1", a.match_cnt); end
    endtask

    task automatic test_load();
        logic [6:0] s, gy;
        logic [3:0] s2, gy2;
        logic ys, yqs;
        do_reset();
        a.ovl = 1'b1;
        // 1,0,1 then a 1 that would complete the default pattern, but load is high.
        step_a(1'b1, 1'b1, ys, yqs);
        step_a(1'b1, 1'b0, ys, yqs);
        step_a(1'b1, 1'b1, ys, yqs);
        a.load   = 1'b1;
        a.pat_in = 4'b0110;
        step_a(1'b1, 1'b1, ys, yqs);
        a.load = 1'b0;
        n_tests++;
        if (ys !== 1'b0 || a.match_cnt !== 8'd0) begin
            n_fail++; $display("FAIL load_blocks_y: got y=%b cnt=%0d expected y=0 cnt=0", ys, a.match_cnt);
        end
        s = 7'b0110110;
        for (int i = 0; i < 7; i++) begin
            step_a(1'b1, s[6-i], ys, yqs);
            gy[6-i] = ys;
        end
        n_tests++;
        if (gy !== 7'b0001001) begin n_fail++; $display("FAIL load_y: got %b expected 0001001", gy); end
        s2 = 4'b1011;
        for (int i = 0; i < 4; i++) begin
            step_a(1'b1, s2[3-i], ys, yqs);
            gy2[3-i] = ys;
        end
        n_tests++;
        if (gy2 !== 4'b0000) begin n_fail++; $display("FAIL load_old_pat: got %b expected 0000", gy2); end
        n_tests++;
        if (a.match_cnt !== 8'd2) begin n_fail++; $display("FAIL load_cnt: got %0d expected 2", a.match_cnt); end
    endtask

    task automatic test_saturate();
        logic [5:0] gy;
        logic ys, yqs;
        do_reset();
        b.ovl = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step_b(1'b1, 1'b1, ys, yqs);
            gy[5-i] = ys;
        end
        n_tests++;
        if (gy !== 6'b011111) begin n_fail++; $display("FAIL sat_y: got %b expected 011111", gy); end
        n_tests++;
        if (b.match_cnt !== 2'd3) begin n_fail++; $display("FAIL sat_cnt: got %0d expected 3", b.match_cnt); end
        b.clr_cnt = 1'b1;
        step_b(1'b1, 1'b1, ys, yqs);
        b.clr_cnt = 1'b0;
        n_tests++;
        if (ys !== 1'b1 || b.match_cnt !== 2'd0) begin
            n_fail++; $display("FAIL clr_wins: got y=%b cnt=%0d expected y=1 cnt=0", ys, b.match_cnt);
        end
        step_b(1'b1, 1'b1, ys, yqs);
        n_tests++;
        if (b.match_cnt !== 2'd1) begin n_fail++; $display("FAIL clr_recount: got %0d expected 1", b.match_cnt); end
    endtask

    task automatic test_async_reset();
        logic [3:0] s;
        logic [4:0] gy;
        logic ys, yqs;
        do_reset();
        a.ovl = 1'b0;
        s = 4'b1011;
        for (int i = 0; i < 4; i++) step_a(1'b1, s[3-i], ys, yqs);
        for (int i = 0; i < 3; i++) step_a(1'b1, s[3-i], ys, yqs);
        n_tests++;
        if (a.match_cnt !== 8'd1) begin n_fail++; $display("FAIL pre_rst_cnt: got %0d expected 1", a.match_cnt); end
        // Mid-cycle, well away from any clock edge.
        rst = 1'b0;
        #1;
        n_tests++;
        if (a.match_cnt !== 8'd0 || a.y_q !== 1'b0) begin
            n_fail++; $display("FAIL async_rst: got cnt=%0d yq=%b expected cnt=0 yq=0", a.match_cnt, a.y_q);
        end
        @(negedge clk);
        rst = 1'b1;
        s = 4'b1011;
        step_a(1'b1, 1'b1, ys, yqs);
        gy[4] = ys;
        for (int i = 0; i < 4; i++) begin
            step_a(1'b1, s[3-i], ys, yqs);
            gy[3-i] = ys;
        end
        n_tests++;
        if (gy !== 5'b00001) begin n_fail++; $display("FAIL post_rst_y: got %b expected 00001", gy); end
        n_tests++;
        if (a.match_cnt !== 8'd1) begin n_fail++; $display("FAIL post_rst_cnt: got %0d expected 1", a.match_cnt); end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_overlap();
        test_nonoverlap();
        test_enable();
        test_load();
        test_saturate();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Backstop so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: simulation still running at %0t, limit 100000", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 Parameter PAT_W, default 4: pattern length in bits, legal range 2..16.
REQ-002 Parameter DEF_PAT, default 4'b1011 (PAT_W bits): pattern value loaded at reset.
REQ-003 Parameter CNT_W, default 8: width of the match counter.
REQ-004 Port clk  input  1: single clock, rising-edge active.
REQ-005 Port rst  input  1: asynchronous, active-low reset.
REQ-006 Port en  input  1: when high, x is consumed this cycle.
REQ-007 Port x  input  1: serial data bit.
REQ-008 Port ovl  input  1: 1 = overlapping detection, 0 = non-overlapping detection.
REQ-009 Port load  input  1: when high, pat_in is captured as the new pattern.
REQ-010 Port pat_in  input  PAT_W: new pattern value; the first-received bit is MSB.
REQ-011 Port clr_cnt  input  1: synchronous clear of match_cnt.
REQ-012 Port y  output  1: Mealy match flag, combinational on the current x.
REQ-013 Port y_q  output  1: y registered, one cycle later.
REQ-014 Port match_cnt  output  CNT_W: number of matches, saturating.

Function
REQ-015 The block SHALL hold a pattern register pat, a history register hist (PAT_W-1 bits, newest bit in LSB) and a fill counter fill (0..PAT_W-1).
REQ-016 The window SHALL be {hist, x}; match = en & ~load & (fill == PAT_W-1) & ({hist, x} == pat).
REQ-017 y SHALL equal match combinationally, with no clock latency, and SHALL be 0 whenever rst is low.
REQ-018 With en=1 and no match, hist SHALL shift left taking x, and fill SHALL increment, saturating at PAT_W-1.
REQ-019 With en=1, a match and ovl=1, hist SHALL shift in x and fill SHALL stay at PAT_W-1, so overlapping matches are found.
REQ-020 With en=1, a match and ovl=0, hist SHALL clear to 0 and fill SHALL clear to 0, so the next match needs PAT_W fresh bits.
REQ-021 With en=0 (and load=0), hist, fill and pat SHALL hold, x SHALL be ignored, and y SHALL be 0.
REQ-022 With load=1, pat SHALL take pat_in and hist and fill SHALL clear at the clock edge; y SHALL be 0 that cycle regardless of en and x.
REQ-023 ovl SHALL be sampled per cycle; a change takes effect on the next match.
REQ-024 match_cnt SHALL increment by 1 on each cycle with match=1 and SHALL saturate at 2^CNT_W-1 without wrapping.
REQ-025 If clr_cnt=1 and match=1 in the same cycle, clr_cnt SHALL win: match_cnt becomes 0, y still pulses.
REQ-026 y_q SHALL be a register of y, updated every clock edge.

Reset
REQ-027 When rst goes low, at any time (including mid-pattern), pat SHALL take DEF_PAT and hist, fill, match_cnt and y_q SHALL take 0 immediately, without waiting for a clock edge.
REQ-028 After rst deasserts, detection SHALL need PAT_W fresh enabled bits before the first match.

Verification
REQ-029 Reset default pattern 1011, ovl=1, en=1, x stream 1,0,1,1,0,1,1 -> y=1 on bits 4 and 7 only; match_cnt=2; y_q high on the cycles after bits 4 and 7.
REQ-030 Same stream with ovl=0 -> y=1 on bit 4 only; match_cnt=1.
REQ-031 Stream 1,0,en=0 for 3 cycles with x toggling,1,1 -> x is ignored while en=0; y=1 on the final bit; match_cnt=1.
REQ-032 load with pat_in=4'b0110, then stream 0,1,1,0,1,1,0 with ovl=1 -> matches on bits 4 and 7; a stream of 1011 gives no match.
REQ-033 CNT_W=2, pattern 11 (PAT_W=2), ovl=1, six consecutive 1s -> y high on bits 2..6; match_cnt saturates at 3; clr_cnt coincident with a match -> match_cnt=0.
REQ-034 rst low asynchronously after bits 1,0,1 of 1011, then released, then 1 -> no match; a full 1,0,1,1 afterwards -> y=1; match_cnt was 0 immediately on rst, without a clock edge.
